// File: rtl/mu0_pkg.sv
// ---------------------------------------------------------------------------
// mu0_pkg
// Shared definitions for the parametrised MU0 core:
//   - 4-bit opcode constants for the 8-instruction ISA
//   - 2-bit FSM state encoding (also exported on the core's state port)
//   - ALU operation selector used by mu0_alu_p
//   - isMemOp(): true for instructions that issue a memory request in EXEC
// ---------------------------------------------------------------------------
package mu0_pkg;

    // Opcodes live in the top four bits of the instruction register.
    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    // State encoding is visible to the host, so the values are fixed.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    typedef enum logic [2:0] {
        ALU_ZERO,
        ALU_ADD,
        ALU_SUB,
        ALU_INC,
        ALU_PASS_B
    } aluOpT;

    // LDA, STO, ADD and SUB are exactly the opcodes 0..3.
    function automatic logic isMemOp(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/mu0_alu_p.sv
// ---------------------------------------------------------------------------
// mu0_alu_p
// Combinational ALU shared by the program-counter increment (FETCH) and the
// accumulator operations (EXEC). All results wrap modulo 2^DATA_W.
// Ports:
//   op  in  aluOpT   operation select
//   a   in  DATA_W   first operand (pc or acc)
//   b   in  DATA_W   second operand (memory read data)
//   y   out DATA_W   result
// ---------------------------------------------------------------------------
module mu0_alu_p
    import mu0_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  aluOpT             op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    always_comb begin
        // NOTE: default assignment first so every path drives y; no latch.
        y = '0;
        case (op)
            ALU_ADD:    y = a + b;
            ALU_SUB:    y = a - b;
            ALU_INC:    y = a + ONE;
            ALU_PASS_B: y = b;
            default:    y = '0;
        endcase
    end

endmodule

// File: rtl/mu0_core_p.sv
// ---------------------------------------------------------------------------
// mu0_core_p
// Parametrised MU0 accumulator core. Memory is external behind a req/ready
// handshake; a request is held until mem_ready completes it, so any number of
// wait states is tolerated.
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   start                 level in IDLE, rising edge in HALT; launches at RESET_PC
//   mem_req/mem_we        request strobe and direction (1 = write)
//   mem_addr/mem_wdata    request address and write data (acc)
//   mem_rdata/mem_ready   read data and completion from memory
//   pc, acc, ir, state    architectural state for observation
//   halted                1 while in HALT
//   illegal               sticky; halt was caused by opcode 8..15
//   retired               instructions completed since start
// ---------------------------------------------------------------------------
module mu0_core_p
    import mu0_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] ir,
    output logic [1:0]        state,
    output logic              halted,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic              startPrev;
    logic              launch;
    aluOpT             aluOp;
    logic [DATA_W-1:0] aluA;
    logic [DATA_W-1:0] aluY;

    assign opcode  = ir[DATA_W-1 -: 4];
    assign operand = ir[ADDR_W-1:0];   // bits between operand and opcode are ignored
    assign halted  = (state == ST_HALT);

    // IDLE launches on the start level; HALT only on a 0->1 transition so a
    // start held high through a run cannot immediately restart it.
    assign launch = ((state == ST_IDLE) && start) ||
                    ((state == ST_HALT) && start && !startPrev);

    // Bus outputs depend only on registered state (state, pc, ir, acc).
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = acc;
        if (state == ST_FETCH) begin
            mem_req = 1'b1;
        end else if ((state == ST_EXEC) && isMemOp(opcode)) begin
            mem_req  = 1'b1;
            mem_we   = (opcode == OP_STO);
            mem_addr = operand;
        end
    end

    // One ALU: increments pc in FETCH, computes the acc result in EXEC.
    always_comb begin
        aluOp = ALU_INC;
        aluA  = {{(DATA_W-ADDR_W){1'b0}}, pc};
        if (state == ST_EXEC) begin
            aluA = acc;
            case (opcode)
                OP_LDA:  aluOp = ALU_PASS_B;
                OP_ADD:  aluOp = ALU_ADD;
                OP_SUB:  aluOp = ALU_SUB;
                default: aluOp = ALU_ZERO;
            endcase
        end
    end

    mu0_alu_p #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op (aluOp),
        .a  (aluA),
        .b  (mem_rdata),
        .y  (aluY)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        startPrev <= start;
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            acc       <= '0;
            ir        <= '0;
            illegal   <= 1'b0;
            retired   <= '0;
            startPrev <= 1'b0;
        end else if (launch) begin
            state   <= ST_FETCH;
            pc      <= RESET_PC;
            acc     <= '0;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= aluY[ADDR_W-1:0];   // wraps mod 2^ADDR_W
                        state <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: if (mem_ready) acc <= aluY;
                        OP_JMP:                 pc <= operand;
                        OP_JGE:                 if (!acc[DATA_W-1]) pc <= operand;
                        OP_JNE:                 if (acc != '0) pc <= operand;
                        default:                ;
                    endcase

                    if (opcode[3]) begin
                        // Opcodes 8..15 trap without retiring.
                        state   <= ST_HALT;
                        illegal <= 1'b1;
                    end else if (opcode == OP_STP) begin
                        state   <= ST_HALT;
                        retired <= retired + CNT_ONE;
                    end else if (!isMemOp(opcode) || mem_ready) begin
                        state   <= ST_FETCH;
                        retired <= retired + CNT_ONE;
                    end
                end

                default: ;   // IDLE and HALT wait for launch
            endcase
        end
    end

endmodule

// File: tb/tb_mu0_core_p.sv
// ---------------------------------------------------------------------------
// tb_mu0_core_p
// Directed bench for mu0_core_p: a 16/12-bit core with a wait-state memory
// model and an 8/4-bit core with a zero-wait memory for the wrap cases.
// ---------------------------------------------------------------------------
module tb_mu0_core_p;
    import mu0_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    // ---------------- 16-bit core ----------------
    logic        reset, start;
    logic        memReq, memWe, memReady, halted, illegal;
    logic [11:0] memAddr, pc;
    logic [15:0] memWdata, memRdata, acc, ir;
    logic [1:0]  state;
    logic [31:0] retired;

    mu0_core_p #(.DATA_W(16), .ADDR_W(12), .RESET_PC(12'h000), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_rdata(memRdata), .mem_ready(memReady),
        .pc(pc), .acc(acc), .ir(ir), .state(state),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    // ---------------- 8-bit core ----------------
    logic        reset8, start8;
    logic        memReq8, memWe8, memReady8, halted8, illegal8;
    logic [3:0]  memAddr8, pc8;
    logic [7:0]  memWdata8, memRdata8, acc8, ir8;
    logic [1:0]  state8;
    logic [31:0] retired8;

    mu0_core_p #(.DATA_W(8), .ADDR_W(4), .RESET_PC(4'h0), .CNT_W(32)) dut8 (
        .clk(clk), .reset(reset8), .start(start8),
        .mem_req(memReq8), .mem_we(memWe8), .mem_addr(memAddr8), .mem_wdata(memWdata8),
        .mem_rdata(memRdata8), .mem_ready(memReady8),
        .pc(pc8), .acc(acc8), .ir(ir8), .state(state8),
        .halted(halted8), .illegal(illegal8), .retired(retired8)
    );

    // ---------------- memory models ----------------
    logic [15:0] mem16 [4096];
    logic [7:0]  mem8  [16];
    int          waitCfg   = 0;
    int          waitCnt   = 0;
    int          writes16  = 0;
    logic        loadEn    = 1'b0;
    logic        loadSel   = 1'b0;
    logic        clearEn   = 1'b0;
    logic [11:0] loadAddr  = '0;
    logic [15:0] loadData  = '0;

    assign memRdata  = mem16[memAddr];
    assign memReady  = memReq && (waitCnt >= waitCfg);
    assign memRdata8 = mem8[memAddr8];
    assign memReady8 = memReq8;

    always @(posedge clk) begin
        if (clearEn) begin
            for (int i = 0; i < 4096; i++) mem16[i] = '0;
            for (int i = 0; i < 16; i++)   mem8[i]  = '0;
        end
        if (loadEn) begin
            if (loadSel) mem8[loadAddr[3:0]] = loadData[7:0];
            else         mem16[loadAddr]     = loadData;
        end
        if (memReq && memReady) begin
            waitCnt <= 0;
            if (memWe) begin
                mem16[memAddr] = memWdata;
                writes16 = writes16 + 1;
            end
        end else if (memReq) begin
            waitCnt <= waitCnt + 1;
        end else begin
            waitCnt <= 0;
        end
        if (memReq8 && memWe8) mem8[memAddr8] = memWdata8;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic poke16(input logic [11:0] a, input logic [15:0] d);
        loadSel = 1'b0; loadAddr = a; loadData = d; loadEn = 1'b1;
        tick();
        loadEn = 1'b0;
    endtask

    task automatic poke8(input logic [3:0] a, input logic [7:0] d);
        loadSel = 1'b1; loadAddr = {8'h00, a}; loadData = {8'h00, d}; loadEn = 1'b1;
        tick();
        loadEn = 1'b0;
    endtask

    task automatic clearMems();
        clearEn = 1'b1;
        tick();
        clearEn = 1'b0;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Counts cycles from FETCH entry until HALT; -1 if the budget expires.
    // stableOk drops if a waited-on request changes while memory is busy.
    logic stableOk;
    task automatic runUntilHalt(input int budget, output int cycles);
        logic       waiting, pReq, pWe;
        logic [11:0] pAddr;
        cycles   = 0;
        stableOk = 1'b1;
        while (state !== ST_HALT && cycles < budget) begin
            waiting = memReq && !memReady;
            pReq = memReq; pWe = memWe; pAddr = memAddr;
            tick();
            cycles++;
            if (waiting && (memReq !== pReq || memWe !== pWe || memAddr !== pAddr))
                stableOk = 1'b0;
        end
        if (state !== ST_HALT) cycles = -1;
    endtask

    task automatic launchRun();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int cycles;
    int w0;
    int guard;

    initial begin
        reset = 1'b1; start = 1'b0; reset8 = 1'b1; start8 = 1'b0;
        clearMems();
        tick();
        reset = 1'b0; reset8 = 1'b0;
        tick();

        // Reset state
        check("rst_state",   state,   2'd0);
        check("rst_pc",      pc,      12'h000);
        check("rst_acc",     acc,     16'h0000);
        check("rst_ir",      ir,      16'h0000);
        check("rst_req",     memReq,  1'b0);
        check("rst_we",      memWe,   1'b0);
        check("rst_halted",  halted,  1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_retired", retired, 32'd0);
        tick();
        check("idle_holds",  state,   2'd0);

        // Straight-line program, zero wait
        poke16(12'h000, 16'h0010);   // LDA 0x010
        poke16(12'h001, 16'h2011);   // ADD 0x011
        poke16(12'h002, 16'h1012);   // STO 0x012
        poke16(12'h003, 16'h7000);   // STP
        poke16(12'h010, 16'd5);
        poke16(12'h011, 16'd7);
        launchRun();
        check("p1_fetch_entry", state, 2'd1);
        check("p1_fetch_req",   memReq, 1'b1);
        runUntilHalt(100, cycles);
        check("p1_cycles",  cycles,        64'd8);
        check("p1_mem12",   mem16[12'h012], 16'd12);
        check("p1_acc",     acc,           16'd12);
        check("p1_retired", retired,       32'd4);
        check("p1_halted",  halted,        1'b1);
        check("p1_illegal", illegal,       1'b0);
        check("p1_pc",      pc,            12'h004);

        // Same program, 3 wait cycles per request: 7 requests x 4 + STP exec
        resetDut();
        poke16(12'h012, 16'h0000);
        waitCfg = 3;
        w0 = writes16;
        launchRun();
        runUntilHalt(200, cycles);
        check("p2_cycles",  cycles,         64'd29);
        check("p2_stable",  stableOk,       1'b1);
        check("p2_mem12",   mem16[12'h012], 16'd12);
        check("p2_acc",     acc,            16'd12);
        check("p2_retired", retired,        32'd4);
        check("p2_writes",  writes16 - w0,  64'd1);
        waitCfg = 0;

        // Countdown loop: 3 -> 0, JNE taken twice
        resetDut();
        clearMems();
        poke16(12'h000, 16'h0020);   // LDA 0x020
        poke16(12'h001, 16'h3021);   // SUB 0x021
        poke16(12'h002, 16'h6001);   // JNE 1
        poke16(12'h003, 16'h7000);   // STP
        poke16(12'h020, 16'd3);
        poke16(12'h021, 16'd1);
        launchRun();
        runUntilHalt(100, cycles);
        check("cd_acc",     acc,     16'd0);
        check("cd_retired", retired, 32'd8);
        check("cd_pc",      pc,      12'h004);
        check("cd_cycles",  cycles,  64'd16);

        // JGE: not taken on negative acc, taken on positive acc
        resetDut();
        clearMems();
        poke16(12'h000, 16'h0020);   // LDA 0x020 (0x8000)
        poke16(12'h001, 16'h5005);   // JGE 5  -> not taken
        poke16(12'h002, 16'h0021);   // LDA 0x021 (0x0001)
        poke16(12'h003, 16'h5006);   // JGE 6  -> taken
        poke16(12'h004, 16'h7000);
        poke16(12'h005, 16'h7000);
        poke16(12'h006, 16'h7000);
        poke16(12'h020, 16'h8000);
        poke16(12'h021, 16'h0001);
        launchRun();
        runUntilHalt(100, cycles);
        check("jge_pc",      pc,      12'h007);
        check("jge_acc",     acc,     16'h0001);
        check("jge_retired", retired, 32'd5);

        // Illegal opcode at pc=2, start held high throughout
        resetDut();
        clearMems();
        poke16(12'h000, 16'h0020);   // LDA 0x020
        poke16(12'h001, 16'h2021);   // ADD 0x021
        poke16(12'h002, 16'hF000);   // illegal
        poke16(12'h020, 16'h1234);
        poke16(12'h021, 16'h0001);
        start = 1'b1;
        tick();
        runUntilHalt(100, cycles);
        check("ill_halted",  halted,  1'b1);
        check("ill_flag",    illegal, 1'b1);
        check("ill_retired", retired, 32'd2);
        check("ill_pc",      pc,      12'h003);
        check("ill_acc",     acc,     16'h1235);
        tick(); tick(); tick();
        check("ill_no_retrigger", state, 2'd3);
        start = 1'b0;
        tick();
        check("ill_still_halt", state, 2'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_state",   state,   2'd1);
        check("restart_illegal", illegal, 1'b0);
        check("restart_pc",      pc,      12'h000);
        check("restart_acc",     acc,     16'h0000);
        check("restart_retired", retired, 32'd0);

        // Reset during a waiting STO
        resetDut();
        clearMems();
        poke16(12'h000, 16'h0010);   // LDA 0x010
        poke16(12'h001, 16'h1030);   // STO 0x030
        poke16(12'h010, 16'd5);
        waitCfg = 3;
        w0 = writes16;
        launchRun();
        guard = 0;
        while (!(state === ST_EXEC && memWe === 1'b1) && guard < 60) begin
            tick();
            guard++;
        end
        check("sto_reached", guard < 60, 1'b1);
        tick();
        check("sto_waiting", memReq && !memReady, 1'b1);
        reset = 1'b1;
        tick();
        check("rsto_state", state,  2'd0);
        check("rsto_req",   memReq, 1'b0);
        check("rsto_acc",   acc,    16'h0000);
        check("rsto_pc",    pc,     12'h000);
        tick();
        reset = 1'b0;
        tick(); tick();
        check("rsto_no_write", writes16 - w0,  64'd0);
        check("rsto_mem30",    mem16[12'h030], 16'h0000);
        waitCfg = 0;

        // 8-bit core: acc wrap on ADD, pc wrap 15 -> 0
        poke8(4'h0, 8'h08);   // LDA 8
        poke8(4'h1, 8'h29);   // ADD 9
        poke8(4'h2, 8'h4F);   // JMP 15
        poke8(4'hF, 8'h70);   // STP
        poke8(4'h8, 8'hF0);
        poke8(4'h9, 8'h20);
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        guard = 0;
        while (state8 !== ST_HALT && guard < 40) begin
            tick();
            guard++;
        end
        check("w8_halted",  halted8,  1'b1);
        check("w8_acc",     acc8,     8'h10);
        check("w8_pc",      pc8,      4'h0);
        check("w8_retired", retired8, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
